ps2_scancode_sequencer: RTL and testbench
=========================================

PS2_SCANCODE_SEQUENCER -- requirements
Module: ps2_scancode_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000; max clk cycles allowed between bytes of one multi-byte sequence.
REQ-002 SHALL have parameter PAUSE_TAIL_BYTES, default 7; bytes following E1 in a Pause sequence.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ps2_received_data  input  8  received byte from the PS/2 receiver.
REQ-006 ps2_received_data_strb  input  1  one-cycle pulse, ps2_received_data valid.
REQ-007 key_code  output  8  scancode of the buffered event.
REQ-008 key_extended  output  1  event carried an E0 or E1 prefix.
REQ-009 key_release  output  1  event carried an F0 prefix (break).
REQ-010 key_valid  output  1  buffered event present; held until accepted.
REQ-011 key_ready  input  1  consumer accepts the event when key_valid=1.
REQ-012 key_overflow  output  1  one-cycle pulse, event dropped because the buffer was full.
REQ-013 seq_error  output  1  one-cycle pulse, sequence aborted (timeout, or 00/FF byte).

Function
REQ-014 States SHALL be: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (skipping the E1 tail).
REQ-015 Bytes SHALL be processed only on cycles with ps2_received_data_strb=1.
REQ-016 IDLE: E0->EXT; F0->BRK; E1->PAUSE with tail counter=PAUSE_TAIL_BYTES; 00 or FF->seq_error, stay IDLE; any other byte->emit {code, ext=0, rel=0}.
REQ-017 EXT: F0->EXT_BRK; any other byte->emit {code, ext=1, rel=0}, go to IDLE.
REQ-018 BRK: any byte->emit {code, ext=0, rel=1}, go to IDLE; EXT_BRK: any byte->emit {code, ext=1, rel=1}, go to IDLE.
REQ-019 PAUSE: each byte decrements the tail counter; on the last byte emit {8'hE1, ext=1, rel=0}, go to IDLE.
REQ-020 In EXT/BRK/EXT_BRK/PAUSE, a byte of 00 or FF SHALL abort to IDLE with seq_error and no emit.
REQ-021 Timeout counter SHALL clear on every strobe and in IDLE, and count in all other states; on reaching TIMEOUT_CYCLES-1, go to IDLE and pulse seq_error.
REQ-022 Strobe and timeout in the same cycle: the strobe SHALL take precedence and no seq_error is raised.
REQ-023 Emit latency: an event from a strobe in cycle N SHALL show key_valid=1 and stable fields in cycle N+1.
REQ-024 Buffer: one entry. Load on emit if empty, or if key_valid&&key_ready in the same cycle (back-to-back, no bubble).
REQ-025 Emit while full and not accepted: the new event SHALL be dropped, the held event unchanged, key_overflow pulses in cycle N+1.
REQ-026 key_valid&&key_ready with no emit SHALL clear key_valid next cycle; key_code/ext/rel SHALL hold their last values.
REQ-027 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES); tail counter width $clog2(PAUSE_TAIL_BYTES+1).

Reset
REQ-028 On rst_n=0 (asynchronous), outputs SHALL be: state=IDLE, counters=0, key_valid=0, key_code=8'h00, key_extended=0, key_release=0, key_overflow=0, seq_error=0.
REQ-029 Reset mid-sequence or with the buffer full SHALL discard all partial and buffered data; the first byte after release is decoded from IDLE.

Structure
REQ-030 Package ps2_pkg SHALL hold the state encoding and the byte constants E0, F0, E1, 00, FF.
REQ-031 The one-entry valid/ready holding buffer SHALL be sub-module ps2_event_buffer; the decode FSM and counters stay in the top.

Verification
REQ-032 Bytes 1C -> one event {1C,0,0}; key_valid held until key_ready=1.
REQ-033 Bytes E0 F0 75 -> one event {75,1,1}; no event for the E0 or F0 bytes.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0}, after the 8th byte.
REQ-035 Byte F0, then no strobe for TIMEOUT_CYCLES (set to 16) -> seq_error pulse at cycle 15, state IDLE; next byte 1C -> {1C,0,0}.
REQ-036 key_ready=0, bytes 1C then 32 -> 1C held, key_overflow pulses once; key_ready=1 while 32 is emitted -> 32 loaded with no bubble.
REQ-037 Bytes E0 then rst_n low mid-stream and released, then 1C -> key_valid=0 during reset, then {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode sequencer types: decoder states, protocol byte values
// and the decoded key event record.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } ps2_state_e;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_event_t;

  // 00 and FF are keyboard error/overrun codes, never part of a valid sequence.
  function automatic logic is_abort_byte(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_scancode_sequencer_if.sv
// Byte input and key event output bundle of the scancode sequencer.
interface ps2_scancode_sequencer_if;

  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;
  logic       key_overflow;
  logic       seq_error;

  modport master (
    output ps2_received_data, ps2_received_data_strb, key_ready,
    input  key_code, key_extended, key_release, key_valid, key_overflow, seq_error
  );

  modport slave (
    input  ps2_received_data, ps2_received_data_strb, key_ready,
    output key_code, key_extended, key_release, key_valid, key_overflow, seq_error
  );

endinterface

// File: rtl/ps2_event_buffer.sv
// One-entry valid/ready holding register for decoded key events; refills in the
// same cycle the held event is taken, drops new events when full and stalled.
module ps2_event_buffer
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  key_event_t push_event,
  input  logic       key_ready,
  output logic       key_valid,
  output key_event_t key_event,
  output logic       key_overflow
);

  logic       valid_q, valid_d;
  key_event_t event_q, event_d;
  logic       overflow_q, overflow_d;
  logic       accept;
  logic       load;

  always_comb begin
    accept     = valid_q && key_ready;
    load       = push && (!valid_q || accept);
    valid_d    = valid_q;
    event_d    = event_q;
    overflow_d = push && valid_q && !key_ready;
    if (load) begin
      valid_d = 1'b1;
      event_d = push_event;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      event_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      event_q    <= event_d;
      overflow_q <= overflow_d;
    end
  end

  assign key_valid    = valid_q;
  assign key_event    = event_q;
  assign key_overflow = overflow_q;

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Folds PS/2 set-2 byte sequences (E0/F0/E1 prefixes) into single key events,
// with an inter-byte timeout that abandons stalled multi-byte sequences.
module ps2_scancode_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 500000,
  parameter int PAUSE_TAIL_BYTES = 7
) (
  input logic                      clk,
  input logic                      rst_n,
  ps2_scancode_sequencer_if.slave  bus
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int TAIL_W = $clog2(PAUSE_TAIL_BYTES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TAIL_W-1:0] TAIL_INIT = TAIL_W'(PAUSE_TAIL_BYTES);
  localparam logic [TAIL_W-1:0] TAIL_ONE  = TAIL_W'(1);

  ps2_state_e        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic              seq_error_q, seq_error_d;
  logic              timeout_hit;
  logic              emit;
  key_event_t        emit_event;
  key_event_t        buf_event;
  logic [7:0]        rx;

  assign rx = bus.ps2_received_data;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    tail_d      = tail_q;
    seq_error_d = 1'b0;
    timeout_hit = 1'b0;
    emit        = 1'b0;
    emit_event  = '0;
    if (bus.ps2_received_data_strb) begin
      tmo_d = '0;
      if (state_q != IDLE && is_abort_byte(rx)) begin
        state_d     = IDLE;
        tail_d      = '0;
        seq_error_d = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx == BYTE_E0) begin
              state_d = EXT;
            end else if (rx == BYTE_F0) begin
              state_d = BRK;
            end else if (rx == BYTE_E1) begin
              state_d = PAUSE;
              tail_d  = TAIL_INIT;
            end else if (is_abort_byte(rx)) begin
              seq_error_d = 1'b1;
            end else begin
              emit       = 1'b1;
              emit_event = '{code: rx, ext: 1'b0, rel: 1'b0};
            end
          end
          EXT: begin
            if (rx == BYTE_F0) begin
              state_d = EXT_BRK;
            end else begin
              emit       = 1'b1;
              emit_event = '{code: rx, ext: 1'b1, rel: 1'b0};
              state_d    = IDLE;
            end
          end
          BRK: begin
            emit       = 1'b1;
            emit_event = '{code: rx, ext: 1'b0, rel: 1'b1};
            state_d    = IDLE;
          end
          EXT_BRK: begin
            emit       = 1'b1;
            emit_event = '{code: rx, ext: 1'b1, rel: 1'b1};
            state_d    = IDLE;
          end
          PAUSE: begin
            // Pause has no break code; the whole tail collapses into one E1 event.
            if (tail_q <= TAIL_ONE) begin
              emit       = 1'b1;
              emit_event = '{code: BYTE_E1, ext: 1'b1, rel: 1'b0};
              state_d    = IDLE;
              tail_d     = '0;
            end else begin
              tail_d = tail_q - 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            tail_d  = '0;
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        timeout_hit = 1'b1;
        state_d     = IDLE;
        tmo_d       = '0;
        tail_d      = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      tail_q      <= '0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      tail_q      <= tail_d;
      seq_error_q <= seq_error_d;
    end
  end

  ps2_event_buffer u_event_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (emit),
    .push_event   (emit_event),
    .key_ready    (bus.key_ready),
    .key_valid    (bus.key_valid),
    .key_event    (buf_event),
    .key_overflow (bus.key_overflow)
  );

  assign bus.key_code     = buf_event.code;
  assign bus.key_extended = buf_event.ext;
  assign bus.key_release  = buf_event.rel;
  // A timeout is flagged in the cycle the limit is reached, unless a byte arrives.
  assign bus.seq_error    = seq_error_q | timeout_hit;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Self-checking bench for ps2_scancode_sequencer: directed protocol scenarios
// plus a randomized byte stream checked against a prefix-flag reference model.
module tb_ps2_scancode_sequencer;

  localparam int TMO = 16;
  localparam int PTB = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_sequencer_if bus_if ();

  ps2_scancode_sequencer #(
    .TIMEOUT_CYCLES   (TMO),
    .PAUSE_TAIL_BYTES (PTB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // {valid, code, ext, rel, overflow, seq_error}
  wire [12:0] dut_vec = {bus_if.key_valid, bus_if.key_code, bus_if.key_extended,
                         bus_if.key_release, bus_if.key_overflow, bus_if.seq_error};
  logic [12:0] exp_vec;

  int total = 0;
  int bad = 0;

  bit       m_valid, m_ext, m_rel, m_ovf, m_err;
  bit [7:0] m_code;
  bit       s_active, s_ext, s_rel;
  int       pause_left, silent;

  task automatic model_reset();
    m_valid = 0; m_code = 8'h00; m_ext = 0; m_rel = 0; m_ovf = 0; m_err = 0;
    s_active = 0; s_ext = 0; s_rel = 0; pause_left = 0; silent = 0;
  endtask

  // One clock cycle of stimulus; exp_vec holds what the outputs must show in it.
  task automatic apply_stimulus(input bit strb, input bit [7:0] d, input bit rdy);
    bit       t_now, emit, err, e_ext, e_rel, accept, abort_b;
    bit [7:0] e_code;
    @(negedge clk);
    bus_if.ps2_received_data      = d;
    bus_if.ps2_received_data_strb = strb;
    bus_if.key_ready              = rdy;
    t_now   = (s_active || pause_left > 0) && !strb && (silent == TMO - 1);
    exp_vec = {m_valid, m_code, m_ext, m_rel, m_ovf, m_err | t_now};
    emit = 0; err = 0; e_code = d; e_ext = 0; e_rel = 0;
    abort_b = (d == 8'h00) || (d == 8'hFF);
    if (strb) begin
      silent = 0;
      if (pause_left > 0) begin
        if (abort_b) begin
          err = 1; pause_left = 0;
        end else begin
          pause_left--;
          if (pause_left == 0) begin emit = 1; e_code = 8'hE1; e_ext = 1; end
        end
      end else if (s_active) begin
        if (abort_b) err = 1;
        else if (d == 8'hF0 && !s_rel) s_rel = 1;
        else begin emit = 1; e_ext = s_ext; e_rel = s_rel; end
        if (err || emit) begin s_active = 0; s_ext = 0; s_rel = 0; end
      end else begin
        case (d)
          8'hE0:        begin s_active = 1; s_ext = 1; end
          8'hF0:        begin s_active = 1; s_rel = 1; end
          8'hE1:        pause_left = PTB;
          8'h00, 8'hFF: err = 1;
          default:      emit = 1;
        endcase
      end
    end else if (s_active || pause_left > 0) begin
      if (t_now) begin
        s_active = 0; s_ext = 0; s_rel = 0; pause_left = 0; silent = 0;
      end else begin
        silent++;
      end
    end
    accept = m_valid && rdy;
    m_ovf  = emit && m_valid && !rdy;
    if (emit && (!m_valid || accept)) begin
      m_valid = 1; m_code = e_code; m_ext = e_ext; m_rel = e_rel;
    end else if (accept) begin
      m_valid = 0;
    end
    m_err = err;
    #1;
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.ps2_received_data_strb = 1'b0;
    bus_if.ps2_received_data      = 8'h00;
    bus_if.key_ready              = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_assert();
    total++;
    if (dut_vec !== 13'h0) begin
      bad++; $display("[TB] FAIL reset_now: got %h want %h", dut_vec, 13'h0);
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (dut_vec !== 13'h0) begin
      bad++; $display("[TB] FAIL reset_hold: got %h want %h", dut_vec, 13'h0);
    end
    reset_release();
  endtask

  task automatic test_make_code();
    bit [7:0] bytes [6] = '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit       strbs [6] = '{1, 0, 0, 0, 0, 0};
    bit       rdys  [6] = '{0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(strbs[i], bytes[i], rdys[i]);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL make_code step %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (i == 3) begin
        total++;
        if (dut_vec !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
          bad++; $display("[TB] FAIL make_code_held: got %h want %h", dut_vec,
                          {1'b1, 8'h1C, 4'b0000});
        end
      end
    end
    total++;
    if (bus_if.key_valid !== 1'b0 || bus_if.key_code !== 8'h1C) begin
      bad++; $display("[TB] FAIL make_code_consumed: got valid=%b code=%h want valid=0 code=1c",
                      bus_if.key_valid, bus_if.key_code);
    end
  endtask

  task automatic test_ext_break();
    bit [7:0] bytes [4] = '{8'hE0, 8'hF0, 8'h75, 8'h00};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i < 3, bytes[i], 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL ext_break step %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (i >= 1 && i <= 2) begin
        total++;
        if (bus_if.key_valid !== 1'b0) begin
          bad++; $display("[TB] FAIL ext_break_no_early_event step %0d: got %b want 0", i,
                          bus_if.key_valid);
        end
      end
    end
    total++;
    if (dut_vec !== {1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL ext_break_event: got %h want %h", dut_vec,
                      {1'b1, 8'h75, 1'b1, 1'b1, 2'b00});
    end
    apply_stimulus(0, 8'h00, 1'b1);
  endtask

  task automatic test_pause();
    bit [7:0] bytes [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int valid_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i < 8, (i < 8) ? bytes[i] : 8'h00, 1'b1);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL pause step %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (bus_if.key_valid) begin
        valid_cycles++;
        total++;
        if (i != 8 || dut_vec !== {1'b1, 8'hE1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
          bad++; $display("[TB] FAIL pause_event step %0d: got %h want step 8 value %h", i,
                          dut_vec, {1'b1, 8'hE1, 1'b1, 3'b000});
        end
      end
    end
    total++;
    if (valid_cycles != 1) begin
      bad++; $display("[TB] FAIL pause_count: got %0d want 1", valid_cycles);
    end
  endtask

  task automatic test_timeout();
    apply_stimulus(1, 8'hF0, 1'b1);
    for (int k = 1; k <= TMO + 1; k++) begin
      apply_stimulus(0, 8'h00, 1'b1);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL timeout step %0d: got %h want %h", k, dut_vec, exp_vec);
      end
      total++;
      if (bus_if.seq_error !== (k == TMO)) begin
        bad++; $display("[TB] FAIL timeout_pulse cycle %0d: got %b want %b", k - 1,
                        bus_if.seq_error, (k == TMO));
      end
    end
    apply_stimulus(1, 8'h1C, 1'b1);
    apply_stimulus(0, 8'h00, 1'b1);
    total++;
    if (dut_vec !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL timeout_recover: got %h want %h", dut_vec, {1'b1, 8'h1C, 4'b0000});
    end
    // Strobe landing on the last allowed cycle wins over the timeout.
    apply_stimulus(1, 8'hF0, 1'b1);
    for (int k = 1; k < TMO; k++) apply_stimulus(0, 8'h00, 1'b1);
    apply_stimulus(1, 8'h1C, 1'b1);
    total++;
    if (bus_if.seq_error !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_precedence: got %b want 0", bus_if.seq_error);
    end
    apply_stimulus(0, 8'h00, 1'b1);
    total++;
    if (dut_vec !== {1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL timeout_precedence_event: got %h want %h", dut_vec,
                      {1'b1, 8'h1C, 1'b0, 1'b1, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    bit [7:0] bytes [7] = '{8'h1C, 8'h00, 8'h32, 8'h00, 8'h00, 8'h32, 8'h00};
    bit       strbs [7] = '{1, 0, 1, 0, 0, 1, 0};
    bit       rdys  [7] = '{0, 0, 0, 0, 0, 1, 0};
    apply_stimulus(0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(strbs[i], bytes[i], rdys[i]);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL back_to_back step %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (i == 3) begin
        total++;
        if (dut_vec !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b0}) begin
          bad++; $display("[TB] FAIL overflow_pulse: got %h want %h", dut_vec,
                          {1'b1, 8'h1C, 2'b00, 2'b10});
        end
      end
      if (i == 4) begin
        total++;
        if (bus_if.key_overflow !== 1'b0) begin
          bad++; $display("[TB] FAIL overflow_once: got %b want 0", bus_if.key_overflow);
        end
      end
    end
    total++;
    if (dut_vec !== {1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL no_bubble_load: got %h want %h", dut_vec, {1'b1, 8'h32, 4'b0000});
    end
    apply_stimulus(0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_midstream();
    apply_stimulus(1, 8'h1C, 1'b0);
    apply_stimulus(1, 8'hE0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus_if.key_valid !== 1'b0 || dut_vec !== 13'h0) begin
      bad++; $display("[TB] FAIL reset_midstream_clear: got %h want %h", dut_vec, 13'h0);
    end
    bus_if.ps2_received_data_strb = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus_if.key_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_midstream_hold: got %b want 0", bus_if.key_valid);
    end
    reset_release();
    apply_stimulus(1, 8'h1C, 1'b1);
    apply_stimulus(0, 8'h00, 1'b1);
    total++;
    if (dut_vec !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL reset_midstream_event: got %h want %h", dut_vec,
                      {1'b1, 8'h1C, 4'b0000});
    end
  endtask

  task automatic test_random();
    bit [7:0] b;
    bit       strb, rdy;
    int       r;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      case (r)
        0:       b = 8'hE0;
        1, 2:    b = 8'hF0;
        3:       b = 8'hE1;
        4:       b = 8'h00;
        5:       b = 8'hFF;
        default: b = 8'($urandom_range(1, 254));
      endcase
      strb = ($urandom_range(0, 2) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        for (int g = 0; g < TMO + 2; g++) begin
          apply_stimulus(0, 8'h00, rdy);
          total++;
          if (dut_vec !== exp_vec) begin
            bad++; $display("[TB] FAIL random_gap step %0d.%0d: got %h want %h", i, g, dut_vec, exp_vec);
          end
        end
      end
      apply_stimulus(strb, b, rdy);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL random step %0d: got %h want %h", i, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    bus_if.ps2_received_data      = 8'h00;
    bus_if.ps2_received_data_strb = 1'b0;
    bus_if.key_ready              = 1'b0;
    model_reset();
    test_reset();
    test_make_code();
    test_ext_break();
    test_pause();
    test_timeout();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
